// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with locked ownership and an optional
// hold limit. Outputs are all registered; there is no input-to-output
// combinational path.
//
// Handshake: a requester raises req[i] and keeps it high. It owns the
// resource for every cycle that gnt[i] is high. Ownership ends when the
// owner pulses done, drops req[i], or the hold limit expires. The hold-limit
// case is flagged by preempt in the same cycle that gnt falls. After each
// ownership gnt stays low for at least one cycle before the next grant.
module rr_lock_arbiter #(
  parameter int WIDTH      = 4,
  parameter int HOLD_LIMIT = 0,
  parameter int IDW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic             preempt,
  output logic             dbg_busy,
  output logic [IDW-1:0]   dbg_ptr
);

  localparam int CW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (HOLD_LIMIT > 0) ? CW'(HOLD_LIMIT - 1) : '0;
  localparam logic [IDW-1:0] ID_TOP = IDW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pre_q, pre_d;

  logic [IDW-1:0]   win_m, win_a, winner;
  logic             hit_m;
  logic             natural_rel, limit_rel;

  // Rotating-priority pick: lowest request at or above ptr, else lowest overall.
  always_comb begin
    win_m = '0;
    win_a = '0;
    hit_m = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr_q))) begin
        win_m = IDW'(i);
        hit_m = 1'b1;
      end
      if (req[i]) begin
        win_a = IDW'(i);
      end
    end
    winner = hit_m ? win_m : win_a;
  end

  // Next-state and next-output logic for the IDLE/BUSY ownership machine.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pre_d       = 1'b0;
    natural_rel = done || ((req & gnt_q) == '0);
    limit_rel   = (HOLD_LIMIT != 0) && (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = BUSY;
          gnt_d   = WIDTH'(1) << winner;
          id_d    = winner;
          ptr_d   = (winner == ID_TOP) ? '0 : winner + IDW'(1);
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (natural_rel || limit_rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          // A natural release in the same cycle takes precedence over the limit.
          pre_d   = limit_rel && !natural_rel;
        end else if (HOLD_LIMIT != 0) begin
          // cnt stops at CNT_LAST, where the limit release fires, so it never wraps.
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (gnt_d != '0);
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign preempt   = pre_q;
  assign dbg_busy  = (state_q == BUSY);
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: one unlimited-hold instance (a) and one
// instance with HOLD_LIMIT=4 (b).
module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic       done_a = 1'b0, done_b = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;
  logic [1:0] id_a, id_b;
  logic       pre_a, pre_b;
  logic       busy_a, busy_b;
  logic [1:0] ptr_a, ptr_b;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  rr_lock_arbiter #(.WIDTH(4), .HOLD_LIMIT(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_valid(valid_a), .gnt_id(id_a), .preempt(pre_a),
    .dbg_busy(busy_a), .dbg_ptr(ptr_a)
  );

  rr_lock_arbiter #(.WIDTH(4), .HOLD_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_valid(valid_b), .gnt_id(id_b), .preempt(pre_b),
    .dbg_busy(busy_b), .dbg_ptr(ptr_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic p);
    check({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    check({tag, ".valid"}, 32'(valid_a), 32'(g != 4'b0));
    check({tag, ".id"}, 32'(id_a), 32'(id));
    check({tag, ".preempt"}, 32'(pre_a), 32'(p));
  endtask

  task automatic check_b(input string tag, input logic [3:0] g, input logic p);
    check({tag, ".gnt"}, 32'(gnt_b), 32'(g));
    check({tag, ".valid"}, 32'(valid_b), 32'(g != 4'b0));
    check({tag, ".preempt"}, 32'(pre_b), 32'(p));
  endtask

  initial begin
    logic [3:0] e;
    int hold_cnt;

    // Reset with all requests high: outputs stay clear
    rst = 1'b1; req_a = 4'b1111;
    step(); step();
    check_a("rst", 4'b0000, 2'd0, 1'b0);
    check("rst.ptr", 32'(ptr_a), 32'd0);
    check("rst.busy", 32'(busy_a), 32'd0);
    check_b("rst_b", 4'b0000, 1'b0);

    // Single grant to requester 2, ptr moves to 3
    rst = 1'b0; req_a = 4'b0100;
    step();
    check_a("single", 4'b0100, 2'd2, 1'b0);
    check("single.ptr", 32'(ptr_a), 32'd3);
    check("single.busy", 32'(busy_a), 32'd1);
    done_a = 1'b1; req_a = 4'b0000;
    step();
    check_a("single_rel", 4'b0000, 2'd2, 1'b0);
    done_a = 1'b0;

    // Masked wrap: ptr=3, req=0011 -> winner 0, ptr 1
    req_a = 4'b0011;
    step();
    check_a("wrap", 4'b0001, 2'd0, 1'b0);
    check("wrap.ptr", 32'(ptr_a), 32'd1);
    done_a = 1'b1; req_a = 4'b0000;
    step();
    check_a("wrap_rel", 4'b0000, 2'd0, 1'b0);
    done_a = 1'b0;

    // Rotation fairness from ptr 0: 0,1,2,3,0 with one idle bubble each
    rst = 1'b1;
    step();
    rst = 1'b0; req_a = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("rot%0d.gnt", k), 32'(gnt_a), 32'(e));
      check($sformatf("rot%0d.valid", k), 32'(valid_a), 32'd1);
      done_a = 1'b1;
      step();
      check($sformatf("rot%0d.bubble", k), 32'(gnt_a), 32'd0);
      done_a = 1'b0;
    end
    check("rot.ptr", 32'(ptr_a), 32'd1);
    check("rot.id", 32'(id_a), 32'd0);
    req_a = 4'b0000;
    step();

    // Request drop: owner 1 holds 3 cycles, then drops; requester 2 waits
    req_a = 4'b0110;
    step();
    check_a("drop.c1", 4'b0010, 2'd1, 1'b0);
    step();
    check_a("drop.c2", 4'b0010, 2'd1, 1'b0);
    step();
    check_a("drop.c3", 4'b0010, 2'd1, 1'b0);
    check("drop.ptr_hold", 32'(ptr_a), 32'd2);
    req_a = 4'b0100;
    step();
    check_a("drop.rel", 4'b0000, 2'd1, 1'b0);
    step();
    check_a("drop.next", 4'b0100, 2'd2, 1'b0);
    req_a = 4'b0000;
    step();
    check_a("drop.idle", 4'b0000, 2'd2, 1'b0);

    // Reset mid-ownership with requester 3 owning
    req_a = 4'b1000;
    step();
    check_a("mid.own", 4'b1000, 2'd3, 1'b0);
    rst = 1'b1; req_a = 4'b1001;
    step();
    check_a("mid.rst", 4'b0000, 2'd0, 1'b0);
    check("mid.ptr", 32'(ptr_a), 32'd0);
    check("mid.busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    step();
    check_a("mid.regrant", 4'b0001, 2'd0, 1'b0);
    req_a = 4'b0000;

    // Hold limit 4: owner 0 for exactly 4 cycles, preempt pulse, then owner 1
    req_b = 4'b0011;
    hold_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_b($sformatf("hold.c%0d", k + 1), 4'b0001, 1'b0);
      if (gnt_b == 4'b0001) hold_cnt++;
    end
    check("hold.cycles", 32'(hold_cnt), 32'd4);
    step();
    check_b("hold.preempt", 4'b0000, 1'b1);
    step();
    check_b("hold.next", 4'b0010, 1'b0);
    check("hold.id", 32'(id_b), 32'd1);
    step(); step(); step();
    check_b("hold.c4_owner1", 4'b0010, 1'b0);
    // done on the 4th cycle: natural release beats the limit
    done_b = 1'b1;
    step();
    check_b("hold.done_c4", 4'b0000, 1'b0);
    done_b = 1'b0;
    step();
    check_b("hold.after", 4'b0001, 1'b0);
    check("hold.ptr", 32'(ptr_b), 32'd1);
    req_b = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
